fig_04b_block_078: RTL and testbench
====================================

FIG_04B_BLOCK_078 -- requirements
Module: fig_04b_block_078

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset; all state updates on the rising edge of clk.
REQ-002 The module SHALL have these ports:
- clk in 1: system clock
- rst in 1: synchronous active-high reset
- instr in 8: current opcode byte
- instr_valid in 1: instr is executing this cycle
- alu_wr in 1: write ALU result z to R[dreg]
- flag_en in 1: update Z and S from z
- cyov_en in 1: update CY and OV from ALU
- z in 16: ALU result
- cy in 1: ALU carry
- ov in 1: ALU overflow
- x out 16: ALU operand, R[sreg], combinational
- y out 16: ALU operand, R[instr[3:0]], combinational
- r15 out 16: R15 contents
- flag_z, flag_s, flag_cy, flag_ov out 1 each: status flags
- flag_b, alt1, alt2 out 1 each: prefix state
- sreg, dreg out 4 each: current source and destination register indices

Function
REQ-003 State SHALL be 16x16 registers R0-R15, plus sreg, dreg, flag_b, alt1, alt2, flag_z, flag_s, flag_cy and flag_ov.
REQ-004 Nothing SHALL change when instr_valid=0.
REQ-005 FROM (0xB0-0xBF) with flag_b=0 SHALL set sreg=instr[3:0]; all other state is held.
REQ-006 TO (0x10-0x1F) with flag_b=0 SHALL set dreg=instr[3:0]; all other state is held.
REQ-007 WITH (0x20-0x2F) SHALL set sreg=dreg=instr[3:0] and flag_b=1.
REQ-008 ALT1 (0x3D) SHALL set alt1=1, alt2=0; ALT2 (0x3E) SHALL set alt1=0, alt2=1; ALT3 (0x3F) SHALL set both; sreg, dreg and flag_b are held.
REQ-009 MOVE (0x1n with flag_b=1) SHALL write R[n]<=R[sreg]; flags are unchanged.
REQ-010 MOVES (0xBn with flag_b=1) SHALL write R[dreg]<=R[n], set Z=(value==0), S=value[15], OV=value[7]; CY is unchanged.
REQ-011 Any other valid opcode is non-prefix. If alu_wr=1, R[dreg]<=z. If flag_en=1, Z=(z==0) and S=z[15]. If cyov_en=1, CY=cy and OV=ov.
REQ-012 Completion of any non-prefix opcode, including MOVE and MOVES, SHALL leave sreg=dreg=0 and flag_b=alt1=alt2=0 on the next cycle.
REQ-013 Register writes and flag updates SHALL be visible on x, y, r15 and the flag outputs one cycle after the executing edge. Reads in the same cycle return the old value; there is no bypass.
REQ-014 On a prefix opcode, alu_wr, flag_en and cyov_en SHALL be ignored; the prefix decode takes precedence.
REQ-015 Prefixes SHALL accumulate: FROM then TO keeps both indices. A repeated prefix SHALL overwrite its own field.
REQ-016 alu_wr with dreg=15 SHALL update r15 like any other register.

Reset
REQ-017 rst=1 SHALL clear all registers R0-R15 to 0x0000, sreg and dreg to 0, and all flags and prefix bits to 0 at the next edge.
REQ-018 Reset SHALL win over any simultaneous instr_valid; a pending prefix chain is discarded.

Structure
REQ-019 Opcode constants (FROM, TO, WITH and ALT1/2/3 bases) and flag bit positions SHALL live in a shared package used by this block and the instruction decoder.
REQ-020 Flag update logic SHALL be a sub-module named fig_06_block_166, instantiated inside this block.

Verification
REQ-021 Reset: set rst=1 for 1 cycle -> all R read 0x0000 via y; sreg=dreg=0; all flags 0.
REQ-022 Prefix chain: issue 0xB3, then 0x15, then a non-prefix op with alu_wr=1 and z=0x1234.
- Required: x=R3 during the op; R5=0x1234 afterwards; sreg=dreg=0 next cycle.
REQ-023 Flags: issue a non-prefix op with z=0x0000, cy=1, ov=0, flag_en=cyov_en=1 -> Z=1, S=0, CY=1, OV=0.
- Then z=0x8000 with flag_en=1 only -> Z=0, S=1, CY still 1.
REQ-024 WITH/MOVE: R2=0xABCD, then 0x22, then 0x17 -> R7=0xABCD, flag_b=0 afterwards, flags unchanged.
REQ-025 MOVES: R4=0x0080, then 0x21, then 0xB4 -> R1=0x0080, Z=0, S=0, OV=1.
REQ-026 Corner cases:
- ALT3 followed by 0x3D -> alt1=1, alt2=0.
- Prefix with alu_wr=1 -> no register write.
- rst during a prefix chain -> sreg=0.

Source files
------------

// File: rtl/fig_04b_block_078_pkg.sv
// Shared opcode constants, flag bit positions and prefix/opcode classification
// used by the register/prefix block and the instruction decoder.
package fig_04b_block_078_pkg;

    localparam logic [3:0] OP_TO_HI   = 4'h1;
    localparam logic [3:0] OP_WITH_HI = 4'h2;
    localparam logic [3:0] OP_FROM_HI = 4'hB;
    localparam logic [7:0] OP_ALT1    = 8'h3D;
    localparam logic [7:0] OP_ALT2    = 8'h3E;
    localparam logic [7:0] OP_ALT3    = 8'h3F;

    localparam int FLAG_Z    = 0;
    localparam int FLAG_S    = 1;
    localparam int FLAG_CY   = 2;
    localparam int FLAG_OV   = 3;
    localparam int NUM_FLAGS = 4;

    typedef enum logic [2:0] {
        OPC_NONE,
        OPC_FROM,
        OPC_TO,
        OPC_WITH,
        OPC_ALT,
        OPC_MOVE,
        OPC_MOVES,
        OPC_ALU
    } op_class_e;

    // FROM/TO become MOVES/MOVE once a WITH prefix has set flag_b.
    function automatic op_class_e op_decode(input logic [7:0] op, input logic flag_b);
        op_class_e cls;
        if (op[7:4] == OP_WITH_HI) begin
            cls = OPC_WITH;
        end else if ((op == OP_ALT1) || (op == OP_ALT2) || (op == OP_ALT3)) begin
            cls = OPC_ALT;
        end else if (op[7:4] == OP_FROM_HI) begin
            cls = flag_b ? OPC_MOVES : OPC_FROM;
        end else if (op[7:4] == OP_TO_HI) begin
            cls = flag_b ? OPC_MOVE : OPC_TO;
        end else begin
            cls = OPC_ALU;
        end
        return cls;
    endfunction

endpackage

// File: rtl/fig_06_block_166.sv
// Status flag register (Z, S, CY, OV) with independent update enables for the
// zero/sign pair, the carry and the overflow bit.
module fig_06_block_166
    import fig_04b_block_078_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 zs_en,
    input  logic [15:0]          zs_val,
    input  logic                 cy_en,
    input  logic                 cy_val,
    input  logic                 ov_en,
    input  logic                 ov_val,
    output logic [NUM_FLAGS-1:0] flags
);

    logic [NUM_FLAGS-1:0] flags_r;
    logic [NUM_FLAGS-1:0] flags_nxt_s;

    // Next flag values; each field holds unless its enable is set.
    always_comb begin
        flags_nxt_s = flags_r;
        if (zs_en) begin
            flags_nxt_s[FLAG_Z] = (zs_val == 16'h0000);
            flags_nxt_s[FLAG_S] = zs_val[15];
        end else begin
            flags_nxt_s[FLAG_Z] = flags_r[FLAG_Z];
            flags_nxt_s[FLAG_S] = flags_r[FLAG_S];
        end
        if (cy_en) begin
            flags_nxt_s[FLAG_CY] = cy_val;
        end else begin
            flags_nxt_s[FLAG_CY] = flags_r[FLAG_CY];
        end
        if (ov_en) begin
            flags_nxt_s[FLAG_OV] = ov_val;
        end else begin
            flags_nxt_s[FLAG_OV] = flags_r[FLAG_OV];
        end
    end

    // Flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_r <= {NUM_FLAGS{1'b0}};
        end else begin
            flags_r <= flags_nxt_s;
        end
    end

    assign flags = flags_r;

endmodule

// File: rtl/fig_04b_block_078.sv
// Register file, prefix state (FROM/TO/WITH/ALTx) and operand routing for the
// ALU; MOVE/MOVES execute here, other opcodes take their result from the ALU.
module fig_04b_block_078
    import fig_04b_block_078_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  instr,
    input  logic        instr_valid,
    input  logic        alu_wr,
    input  logic        flag_en,
    input  logic        cyov_en,
    input  logic [15:0] z,
    input  logic        cy,
    input  logic        ov,
    output logic [15:0] x,
    output logic [15:0] y,
    output logic [15:0] r15,
    output logic        flag_z,
    output logic        flag_s,
    output logic        flag_cy,
    output logic        flag_ov,
    output logic        flag_b,
    output logic        alt1,
    output logic        alt2,
    output logic [3:0]  sreg,
    output logic [3:0]  dreg
);

    logic [15:0]          regs_r [16];
    logic [3:0]           sreg_r, dreg_r, sreg_nxt_s, dreg_nxt_s;
    logic                 flag_b_r, alt1_r, alt2_r;
    logic                 flag_b_nxt_s, alt1_nxt_s, alt2_nxt_s;
    op_class_e            dec_s;
    logic [3:0]           n_s;
    logic [15:0]          src_s, opnd_s;
    logic                 wr_en_s;
    logic [3:0]           wr_idx_s;
    logic [15:0]          wr_data_s;
    logic                 zs_en_s, cy_en_s, cy_val_s, ov_en_s, ov_val_s;
    logic [15:0]          zs_val_s;
    logic [NUM_FLAGS-1:0] flags_s;

    assign n_s    = instr[3:0];
    assign src_s  = regs_r[sreg_r];
    assign opnd_s = regs_r[n_s];

    // Opcode classification; an idle cycle decodes to nothing.
    always_comb begin
        dec_s = OPC_NONE;
        if (instr_valid) begin
            dec_s = op_decode(instr, flag_b_r);
        end else begin
            dec_s = OPC_NONE;
        end
    end

    // Register write port and flag update requests.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_idx_s  = 4'h0;
        wr_data_s = 16'h0000;
        zs_en_s   = 1'b0;
        zs_val_s  = 16'h0000;
        cy_en_s   = 1'b0;
        cy_val_s  = 1'b0;
        ov_en_s   = 1'b0;
        ov_val_s  = 1'b0;
        case (dec_s)
            OPC_MOVE: begin
                wr_en_s   = 1'b1;
                wr_idx_s  = n_s;
                wr_data_s = src_s;
            end
            OPC_MOVES: begin
                wr_en_s   = 1'b1;
                wr_idx_s  = dreg_r;
                wr_data_s = opnd_s;
                zs_en_s   = 1'b1;
                zs_val_s  = opnd_s;
                ov_en_s   = 1'b1;
                ov_val_s  = opnd_s[7];
            end
            OPC_ALU: begin
                wr_en_s   = alu_wr;
                wr_idx_s  = dreg_r;
                wr_data_s = z;
                zs_en_s   = flag_en;
                zs_val_s  = z;
                cy_en_s   = cyov_en;
                cy_val_s  = cy;
                ov_en_s   = cyov_en;
                ov_val_s  = ov;
            end
            default: begin
                wr_en_s = 1'b0;
            end
        endcase
    end

    // Prefix state: prefixes accumulate, any completing opcode clears them.
    always_comb begin
        sreg_nxt_s   = sreg_r;
        dreg_nxt_s   = dreg_r;
        flag_b_nxt_s = flag_b_r;
        alt1_nxt_s   = alt1_r;
        alt2_nxt_s   = alt2_r;
        case (dec_s)
            OPC_FROM: sreg_nxt_s = n_s;
            OPC_TO:   dreg_nxt_s = n_s;
            OPC_WITH: begin
                sreg_nxt_s   = n_s;
                dreg_nxt_s   = n_s;
                flag_b_nxt_s = 1'b1;
            end
            OPC_ALT: begin
                alt1_nxt_s = (instr != OP_ALT2);
                alt2_nxt_s = (instr != OP_ALT1);
            end
            OPC_MOVE, OPC_MOVES, OPC_ALU: begin
                sreg_nxt_s   = 4'h0;
                dreg_nxt_s   = 4'h0;
                flag_b_nxt_s = 1'b0;
                alt1_nxt_s   = 1'b0;
                alt2_nxt_s   = 1'b0;
            end
            default: begin
                sreg_nxt_s = sreg_r;
            end
        endcase
    end

    // Prefix state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg_r   <= 4'h0;
            dreg_r   <= 4'h0;
            flag_b_r <= 1'b0;
            alt1_r   <= 1'b0;
            alt2_r   <= 1'b0;
        end else begin
            sreg_r   <= sreg_nxt_s;
            dreg_r   <= dreg_nxt_s;
            flag_b_r <= flag_b_nxt_s;
            alt1_r   <= alt1_nxt_s;
            alt2_r   <= alt2_nxt_s;
        end
    end

    // Register file with a single write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                regs_r[i] <= 16'h0000;
            end
        end else if (wr_en_s) begin
            regs_r[wr_idx_s] <= wr_data_s;
        end
    end

    fig_06_block_166 u_flags (
        .clk    (clk),
        .rst    (rst),
        .zs_en  (zs_en_s),
        .zs_val (zs_val_s),
        .cy_en  (cy_en_s),
        .cy_val (cy_val_s),
        .ov_en  (ov_en_s),
        .ov_val (ov_val_s),
        .flags  (flags_s)
    );

    assign x       = src_s;
    assign y       = opnd_s;
    assign r15     = regs_r[15];
    assign flag_z  = flags_s[FLAG_Z];
    assign flag_s  = flags_s[FLAG_S];
    assign flag_cy = flags_s[FLAG_CY];
    assign flag_ov = flags_s[FLAG_OV];
    assign flag_b  = flag_b_r;
    assign alt1    = alt1_r;
    assign alt2    = alt2_r;
    assign sreg    = sreg_r;
    assign dreg    = dreg_r;

endmodule

// File: tb/tb_fig_04b_block_078.sv
// Bench for fig_04b_block_078: instruction-level reference model checked every
// cycle, directed prefix/move/flag scenarios, then randomized opcode streams.
module tb_fig_04b_block_078;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  instr;
    logic        instr_valid, alu_wr, flag_en, cyov_en, cy, ov;
    logic [15:0] z;
    logic [15:0] x, y, r15;
    logic        flag_z, flag_s, flag_cy, flag_ov, flag_b, alt1, alt2;
    logic [3:0]  sreg, dreg;

    int tests = 0;
    int fails = 0;
    bit chk_on = 1'b0;

    // Reference model state (instruction-set view)
    logic [15:0] m_r [16];
    logic [3:0]  m_sreg, m_dreg;
    logic        m_b, m_a1, m_a2, m_z, m_s, m_cy, m_ov;

    fig_04b_block_078 dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .alu_wr(alu_wr), .flag_en(flag_en), .cyov_en(cyov_en), .z(z), .cy(cy), .ov(ov),
        .x(x), .y(y), .r15(r15), .flag_z(flag_z), .flag_s(flag_s), .flag_cy(flag_cy),
        .flag_ov(flag_ov), .flag_b(flag_b), .alt1(alt1), .alt2(alt2), .sreg(sreg), .dreg(dreg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: one instruction executes per valid edge.
    always @(posedge clk) begin
        logic [3:0]  n;
        logic [15:0] v;
        n = instr[3:0];
        if (rst) begin
            for (int i = 0; i < 16; i++) m_r[i] = 16'h0000;
            m_sreg = 4'h0; m_dreg = 4'h0;
            {m_b, m_a1, m_a2, m_z, m_s, m_cy, m_ov} = 7'b0;
        end else if (instr_valid) begin
            if (instr >= 8'h20 && instr <= 8'h2F) begin
                m_sreg = n; m_dreg = n; m_b = 1'b1;
            end else if (instr == 8'h3D) begin
                m_a1 = 1'b1; m_a2 = 1'b0;
            end else if (instr == 8'h3E) begin
                m_a1 = 1'b0; m_a2 = 1'b1;
            end else if (instr == 8'h3F) begin
                m_a1 = 1'b1; m_a2 = 1'b1;
            end else if (instr >= 8'hB0 && instr <= 8'hBF && !m_b) begin
                m_sreg = n;
            end else if (instr >= 8'h10 && instr <= 8'h1F && !m_b) begin
                m_dreg = n;
            end else begin
                if (instr >= 8'h10 && instr <= 8'h1F) begin
                    m_r[n] = m_r[m_sreg];
                end else if (instr >= 8'hB0 && instr <= 8'hBF) begin
                    v = m_r[n];
                    m_r[m_dreg] = v;
                    m_z = (v == 16'h0000); m_s = v[15]; m_ov = v[7];
                end else begin
                    if (flag_en) begin m_z = (z == 16'h0000); m_s = z[15]; end
                    if (cyov_en) begin m_cy = cy; m_ov = ov; end
                    if (alu_wr) m_r[m_dreg] = z;
                end
                m_sreg = 4'h0; m_dreg = 4'h0;
                m_b = 1'b0; m_a1 = 1'b0; m_a2 = 1'b0;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("x",    x,   m_r[m_sreg]);
            chk("y",    y,   m_r[instr[3:0]]);
            chk("r15",  r15, m_r[15]);
            chk("sreg", {12'h000, sreg}, {12'h000, m_sreg});
            chk("dreg", {12'h000, dreg}, {12'h000, m_dreg});
            chk("flags", {9'h000, flag_z, flag_s, flag_cy, flag_ov, flag_b, alt1, alt2},
                         {9'h000, m_z, m_s, m_cy, m_ov, m_b, m_a1, m_a2});
        end
    end

    task automatic op(input logic [7:0] i, input logic aw, input logic fe, input logic ce,
                      input logic [15:0] zz, input logic c, input logic o);
        instr = i; instr_valid = 1'b1; alu_wr = aw; flag_en = fe; cyov_en = ce;
        z = zz; cy = c; ov = o;
        @(posedge clk); #1;
        instr_valid = 1'b0; alu_wr = 1'b0; flag_en = 1'b0; cyov_en = 1'b0;
    endtask

    task automatic wr_reg(input logic [3:0] n, input logic [15:0] v);
        op({4'h1, n}, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        op(8'h05, 1'b1, 1'b0, 1'b0, v, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic [3:0] n, output logic [15:0] v);
        instr = {4'h0, n}; instr_valid = 1'b0;
        #1;
        v = y;
    endtask

    initial begin
        logic [15:0] v;
        int k;
        rst = 1'b1; instr = 8'h00; instr_valid = 1'b0; alu_wr = 1'b0;
        flag_en = 1'b0; cyov_en = 1'b0; z = 16'h0000; cy = 1'b0; ov = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_on = 1'b1;

        // Reset state
        for (int i = 0; i < 16; i++) begin
            rd(i[3:0], v);
            chk("reset_reg", v, 16'h0000);
        end
        chk("reset_idx", {8'h00, sreg, dreg}, 16'h0000);
        chk("reset_flags", {9'h000, flag_z, flag_s, flag_cy, flag_ov, flag_b, alt1, alt2}, 16'h0000);

        // Prefix chain FROM 3, TO 5, ALU write
        wr_reg(4'd3, 16'h3333);
        op(8'hB3, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        op(8'h15, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        instr = 8'h05; instr_valid = 1'b1; alu_wr = 1'b1; z = 16'h1234;
        #2;
        chk("chain_x", x, 16'h3333);
        @(posedge clk); #1;
        instr_valid = 1'b0; alu_wr = 1'b0;
        chk("chain_idx", {8'h00, sreg, dreg}, 16'h0000);
        rd(4'd5, v);
        chk("chain_r5", v, 16'h1234);

        // Flags
        op(8'h05, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);
        chk("flags1", {12'h000, flag_z, flag_s, flag_cy, flag_ov}, 16'h000A);
        op(8'h05, 1'b0, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);
        chk("flags2", {12'h000, flag_z, flag_s, flag_cy, flag_ov}, 16'h0006);

        // WITH / MOVE
        wr_reg(4'd2, 16'hABCD);
        op(8'h22, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        op(8'h17, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        rd(4'd7, v);
        chk("move_r7", v, 16'hABCD);
        chk("move_b_flags", {11'h000, flag_b, flag_z, flag_s, flag_cy, flag_ov}, 16'h0006);

        // WITH / MOVES
        wr_reg(4'd4, 16'h0080);
        op(8'h21, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        op(8'hB4, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        rd(4'd1, v);
        chk("moves_r1", v, 16'h0080);
        chk("moves_flags", {12'h000, flag_z, flag_s, flag_cy, flag_ov}, 16'h0003);

        // ALT3 then ALT1
        op(8'h3F, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        op(8'h3D, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        chk("alt", {14'h0000, alt1, alt2}, 16'h0002);
        op(8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);

        // Prefix with alu_wr must not write
        op(8'h16, 1'b1, 1'b1, 1'b1, 16'hDEAD, 1'b0, 1'b0);
        rd(4'd0, v);
        chk("prefix_nowr_r0", v, 16'h0000);
        chk("prefix_dreg", {12'h000, dreg}, 16'h0006);
        op(8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);

        // Reset during a prefix chain
        op(8'hB9, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        rst = 1'b1;
        op(8'h15, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        rst = 1'b0;
        chk("rst_chain_idx", {8'h00, sreg, dreg}, 16'h0000);

        // Randomized streams
        for (int c = 0; c < 3000; c++) begin
            k = $urandom_range(0, 9);
            case (k)
                0, 1:    instr = {4'hB, 4'($urandom_range(0, 15))};
                2, 3:    instr = {4'h1, 4'($urandom_range(0, 15))};
                4:       instr = {4'h2, 4'($urandom_range(0, 15))};
                5:       instr = 8'($urandom_range(8'h3D, 8'h3F));
                default: instr = 8'($urandom);
            endcase
            instr_valid = ($urandom_range(0, 7) != 0);
            alu_wr  = 1'($urandom);
            flag_en = 1'($urandom);
            cyov_en = 1'($urandom);
            z  = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            cy = 1'($urandom);
            ov = 1'($urandom);
            rst = ($urandom_range(0, 99) == 0);
            @(posedge clk); #1;
        end
        rst = 1'b0; instr_valid = 1'b0;
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
